// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-byte register file: bytes 0..1 read status, bytes 2..7 are read/write controls.
// Optional SCL-low bus timeout is enabled by defining I2C_TIMEOUT_EN.
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR       = 7'h50,
    parameter int         FILT_LEN       = 3,
    parameter int         TIMEOUT_CYCLES = 1750000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] status_i,
    output logic [47:0] ctrl_o,
    output logic        wr_strobe,
    output logic [2:0]  wr_index,
    output logic        busy
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RD_MACK, ST_WAIT_STOP
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [2:0]  ptr_reg, ptr_next;
    logic        rw_reg, rw_next;
    logic        ack_phase_reg, ack_phase_next;
    logic        sda_oe_reg, sda_oe_next;
    logic        busy_reg, busy_next;
    logic        wr_strobe_reg;
    logic [2:0]  wr_index_reg, wr_index_next;
    logic        wr_en;

    logic [1:0]  scl_sync_reg, sda_sync_reg;
    logic [1:0]  raw_lvl, filt_lvl;
    logic        scl_f, sda_f, scl_prev_reg, sda_prev_reg;
    logic        scl_rise, scl_fall, start_det, stop_det, to_hit;
    logic [7:0]  rx_byte;
    logic [2:0]  rd_idx;
    logic [7:0]  regs_view [8];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], scl_i};
            sda_sync_reg <= {sda_sync_reg[0], sda_i};
            scl_prev_reg <= scl_f;
            sda_prev_reg <= sda_f;
        end
    end

    assign raw_lvl = {sda_sync_reg[1], scl_sync_reg[1]};

    // Level follows the input only after FILT_LEN consecutive differing samples.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic       lvl_reg;
            logic [3:0] cnt_reg;
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    lvl_reg <= 1'b1;
                    cnt_reg <= '0;
                end else if (raw_lvl[gi] == lvl_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == 4'(FILT_LEN - 1)) begin
                    lvl_reg <= raw_lvl[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
            end
            assign filt_lvl[gi] = lvl_reg;
        end
    endgenerate

    assign scl_f     = filt_lvl[0];
    assign sda_f     = filt_lvl[1];
    assign scl_rise  = scl_f & ~scl_prev_reg;
    assign scl_fall  = ~scl_f & scl_prev_reg;
    assign start_det = scl_f & scl_prev_reg & sda_prev_reg & ~sda_f;
    assign stop_det  = scl_f & scl_prev_reg & ~sda_prev_reg & sda_f;
    assign rx_byte   = {shift_reg[6:0], sda_f};

    assign regs_view[0] = status_i[7:0];
    assign regs_view[1] = status_i[15:8];

    generate
        for (gi = 0; gi < 6; gi++) begin : g_ctrl
            logic [7:0] byte_reg;
            always_ff @(posedge clk_clk) begin
                if (reset_reset)
                    byte_reg <= '0;
                else if (wr_en && ptr_reg == 3'(gi + 2))
                    byte_reg <= rx_byte;
            end
            assign regs_view[gi + 2] = byte_reg;
            assign ctrl_o[8*gi +: 8] = byte_reg;
        end
    endgenerate

    // A master ACK reloads from the following register, so look one ahead there.
    assign rd_idx = (state_reg == ST_RD_MACK) ? ptr_reg + 3'd1 : ptr_reg;

`ifdef I2C_TIMEOUT_EN
    logic [31:0] to_cnt_reg;
    assign to_hit = busy_reg & ~scl_f & (to_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk_clk) begin
        if (reset_reset || !busy_reg || scl_f || to_hit)
            to_cnt_reg <= '0;
        else
            to_cnt_reg <= to_cnt_reg + 32'd1;
    end
`else
    // No timeout: a stalled master holds the state indefinitely.
    assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            ptr_reg       <= '0;
            rw_reg        <= 1'b0;
            ack_phase_reg <= 1'b0;
            sda_oe_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_index_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            rw_reg        <= rw_next;
            ack_phase_reg <= ack_phase_next;
            sda_oe_reg    <= sda_oe_next;
            busy_reg      <= busy_next;
            wr_strobe_reg <= wr_en;
            wr_index_reg  <= wr_index_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        ptr_next       = ptr_reg;
        rw_next        = rw_reg;
        ack_phase_next = ack_phase_reg;
        sda_oe_next    = sda_oe_reg;
        busy_next      = busy_reg;
        wr_en          = 1'b0;
        wr_index_next  = wr_index_reg;

        if (to_hit) begin
            state_next   = ST_IDLE;
            sda_oe_next  = 1'b0;
            busy_next    = 1'b0;
            bit_cnt_next = '0;
        end else if (start_det) begin
            state_next     = ST_ADDR;
            bit_cnt_next   = '0;
            ack_phase_next = 1'b0;
            sda_oe_next    = 1'b0;
            busy_next      = 1'b0;
        end else if (stop_det) begin
            state_next  = ST_IDLE;
            sda_oe_next = 1'b0;
            busy_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR: if (scl_rise) begin
                    shift_next   = rx_byte;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) begin
                        bit_cnt_next = '0;
                        if (rx_byte[7:1] == I2C_ADDR) begin
                            state_next     = ST_ADDR_ACK;
                            busy_next      = 1'b1;
                            rw_next        = rx_byte[0];
                            ack_phase_next = 1'b0;
                            if (rx_byte[0])
                                shift_next = regs_view[rd_idx];
                        end else begin
                            state_next = ST_WAIT_STOP;
                        end
                    end
                end
                // First falling edge drives the ACK, the second one ends the ACK bit.
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    if (!ack_phase_reg) begin
                        sda_oe_next    = 1'b1;
                        ack_phase_next = 1'b1;
                    end else begin
                        ack_phase_next = 1'b0;
                        if (state_reg == ST_ADDR_ACK && rw_reg) begin
                            state_next  = ST_RDATA;
                            sda_oe_next = ~shift_reg[7];
                        end else begin
                            state_next  = (state_reg == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                            sda_oe_next = 1'b0;
                        end
                    end
                end
                ST_PTR, ST_WDATA: if (scl_rise) begin
                    shift_next   = rx_byte;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) begin
                        bit_cnt_next = '0;
                        if (state_reg == ST_PTR) begin
                            ptr_next   = rx_byte[2:0];
                            state_next = ST_PTR_ACK;
                        end else begin
                            if (ptr_reg >= 3'd2) begin
                                wr_en         = 1'b1;
                                wr_index_next = ptr_reg;
                            end
                            ptr_next   = ptr_reg + 3'd1;
                            state_next = ST_WDATA_ACK;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise && bit_cnt_reg != 4'd8) begin
                        shift_next   = {shift_reg[6:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = '0;
                            state_next   = ST_RD_MACK;
                        end else begin
                            sda_oe_next = ~shift_reg[7];
                        end
                    end
                end
                ST_RD_MACK: if (scl_rise) begin
                    if (!sda_f) begin
                        ptr_next   = ptr_reg + 3'd1;
                        shift_next = regs_view[rd_idx];
                        state_next = ST_RDATA;
                    end else begin
                        state_next = ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: sda_oe_next = 1'b0;
                default: ;
            endcase
        end
    end

    assign sda_oe    = sda_oe_reg;
    assign busy      = busy_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_index  = wr_index_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-level I2C master, transaction-level register model and scoreboard monitors.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam int Q = 10;

    logic        clk = 1'b0;
    logic        srst;
    logic        scl_drv, sda_drv;
    logic        sda_oe, wr_strobe, busy;
    logic [15:0] status_i;
    logic [47:0] ctrl_o;
    logic [2:0]  wr_index;
    wire         sda_line = sda_drv & ~sda_oe;

    always #10 clk = ~clk;

    i2c_target_regs dut (
        .clk_clk    (clk),
        .reset_reset(srst),
        .scl_i      (scl_drv),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .status_i   (status_i),
        .ctrl_o     (ctrl_o),
        .wr_strobe  (wr_strobe),
        .wr_index   (wr_index),
        .busy       (busy)
    );

    int          tests = 0;
    int          fails = 0;
    int          exp_q[$];
    string       exp_n[$];
    int          rsp_q[$];
    int          wr_q[$];
    logic [7:0]  wdata_q[$];
    logic [7:0]  m_reg[8];
    int          m_ptr;
    bit          oe_seen;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [47:0] model_ctrl();
        logic [47:0] v;
        for (int i = 2; i < 8; i++) v[8*(i-2) +: 8] = m_reg[i];
        return v;
    endfunction

    // Bus-response monitor: ACK bits and read bytes as seen by the master.
    initial begin
        int r, e;
        string n;
        forever begin
            @(negedge clk);
            if (rsp_q.size() > 0) begin
                r = rsp_q.pop_front();
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_rsp: got 0x%0h, required no response", r);
                end else begin
                    e = exp_q.pop_front();
                    n = exp_n.pop_front();
                    check(n, 48'(r), 48'(e));
                end
            end
        end
    end

    // Write monitor: every strobe must match the next modelled register write.
    initial begin
        int e;
        logic [47:0] tmp;
        forever begin
            @(negedge clk);
            if (sda_oe === 1'b1) oe_seen = 1'b1;
            if (wr_strobe === 1'b1) begin
                if (wr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_strobe: got pulse index=%0d, required none", wr_index);
                end else begin
                    e = wr_q.pop_front();
                    check("wr_index", 48'(wr_index), 48'(e >> 8));
                    tmp = ctrl_o >> (8 * ((e >> 8) - 2));
                    check("wr_data", 48'(tmp[7:0]), 48'(e & 255));
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_xfer(input logic d, output logic s);
        wait_q();
        sda_drv = d;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        s = sda_line;
        wait_q();
        scl_drv = 1'b0;
    endtask

    task automatic i2c_start();
        wait_q();
        sda_drv = 1'b1;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        sda_drv = 1'b0;
        wait_q();
        scl_drv = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_q();
        sda_drv = 1'b0;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        sda_drv = 1'b1;
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic exp_nack);
        logic s;
        exp_q.push_back(int'(exp_nack));
        exp_n.push_back("ack_bit");
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, s);
        rsp_q.push_back(int'(s));
    endtask

    task automatic recv_byte(input logic [7:0] expv, input logic mnack);
        logic s;
        logic [7:0] v;
        v = '0;
        exp_q.push_back(int'(expv));
        exp_n.push_back("read_byte");
        for (int i = 0; i < 8; i++) begin
            bit_xfer(1'b1, s);
            v = {v[6:0], s};
        end
        rsp_q.push_back(int'(v));
        bit_xfer(mnack, s);
    endtask

    task automatic write_txn(input logic [7:0] pbyte);
        logic [7:0] d;
        $display("[TB] write ptr=%0d bytes=%0d", pbyte[2:0], wdata_q.size());
        i2c_start();
        send_byte(8'hA0, 1'b0);
        check("busy_after_addr", 48'(busy), 48'd1);
        send_byte(pbyte, 1'b0);
        m_ptr = int'(pbyte[2:0]);
        while (wdata_q.size() > 0) begin
            d = wdata_q.pop_front();
            if (m_ptr >= 2) begin
                m_reg[m_ptr] = d;
                wr_q.push_back(m_ptr * 256 + int'(d));
            end
            m_ptr = (m_ptr + 1) % 8;
            send_byte(d, 1'b0);
        end
        i2c_stop();
        check("busy_after_stop", 48'(busy), 48'd0);
        check("ctrl_o", ctrl_o, model_ctrl());
    endtask

    task automatic read_txn(input bit set_ptr, input logic [7:0] pbyte, input int n, input logic [15:0] st);
        logic [7:0] e;
        status_i = st;
        $display("[TB] read set_ptr=%0d ptr=%0d bytes=%0d status=%h", set_ptr, pbyte[2:0], n, st);
        i2c_start();
        if (set_ptr) begin
            send_byte(8'hA0, 1'b0);
            send_byte(pbyte, 1'b0);
            m_ptr = int'(pbyte[2:0]);
            i2c_start();
        end
        send_byte(8'hA1, 1'b0);
        for (int k = 0; k < n; k++) begin
            e = (m_ptr == 0) ? st[7:0] : (m_ptr == 1) ? st[15:8] : m_reg[m_ptr];
            recv_byte(e, (k == n - 1));
            if (k != n - 1) m_ptr = (m_ptr + 1) % 8;
        end
        check("sda_oe_after_nack", 48'(sda_oe), 48'd0);
        i2c_stop();
        check("busy_after_stop", 48'(busy), 48'd0);
    endtask

    initial begin
        logic s;
        logic [47:0] ctrl_before;
        int guard;
        srst = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        status_i = '0;
        oe_seen = 1'b0;
        m_ptr = 0;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        repeat (5) @(negedge clk);
        srst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sda_oe", 48'(sda_oe), 48'd0);
        check("reset_ctrl_o", ctrl_o, 48'd0);
        check("reset_wr_strobe", 48'(wr_strobe), 48'd0);
        check("reset_wr_index", 48'(wr_index), 48'd0);
        check("reset_busy", 48'(busy), 48'd0);

        wdata_q = '{8'h5A, 8'hC3};
        write_txn(8'h02);
        check("ctrl_lo16", 48'(ctrl_o[15:0]), 48'hC35A);

        read_txn(1'b1, 8'h00, 2, 16'hBEEF);

        $display("[TB] wrong address 0x51");
        ctrl_before = ctrl_o;
        oe_seen = 1'b0;
        i2c_start();
        send_byte(8'hA2, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h77, 1'b1);
        i2c_stop();
        check("nack_oe_never", 48'(oe_seen), 48'd0);
        check("nack_ctrl_kept", ctrl_o, ctrl_before);

        wdata_q = '{8'h11, 8'h22};
        write_txn(8'h07);
        check("reg7", 48'(ctrl_o[47:40]), 48'h11);

        for (int t = 0; t < 12; t++) begin
            int kind, n;
            kind = int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 4));
            if (kind == 0) begin
                for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
                write_txn(8'($urandom));
            end else begin
                read_txn(kind == 1, 8'($urandom), n, 16'($urandom));
            end
        end

        $display("[TB] reset during read byte");
        wdata_q = '{};
        write_txn(8'h00);
        status_i = 16'h0000;
        i2c_start();
        send_byte(8'hA1, 1'b0);
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, s);
        guard = 0;
        while (sda_oe !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("sda_oe_before_reset", 48'(sda_oe), 48'd1);
        srst = 1'b1;
        @(negedge clk);
        check("reset_mid_sda_oe", 48'(sda_oe), 48'd0);
        check("reset_mid_busy", 48'(busy), 48'd0);
        check("reset_mid_ctrl", ctrl_o, 48'd0);
        srst = 1'b0;
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_ptr = 0;
        for (int i = 0; i < 6; i++) bit_xfer(1'b1, s);
        i2c_stop();

        wdata_q = '{8'h3C};
        write_txn(8'h04);
        read_txn(1'b1, 8'h04, 1, 16'h1234);

        guard = 0;
        while ((exp_q.size() > 0 || wr_q.size() > 0) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("pending_bus_expectations", 48'(exp_q.size()), 48'd0);
        check("pending_write_expectations", 48'(wr_q.size()), 48'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
